// File: rtl/seq_mult_pkg.sv
// seq_mult shared types and sizing.
// Operand/product widths and the FSM state encoding.
package seq_mult_pkg;

  localparam int MUL_W  = 16;
  localparam int PROD_W = 2 * MUL_W;
  localparam int CNT_W  = $clog2(MUL_W);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_e;

  // |x| in MUL_W bits; the most negative value maps to
  // itself, which reads correctly as an unsigned magnitude.
  function automatic logic [MUL_W-1:0] mag(
    input logic [MUL_W-1:0] x,
    input logic             sgn
  );
    return (sgn && x[MUL_W-1]) ? -x : x;
  endfunction

endpackage

// File: rtl/seq_mult_if.sv
// seq_mult operand/product handshake bundle.
// master = upstream issuer + downstream consumer, slave = multiplier.
interface seq_mult_if;
  import seq_mult_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [MUL_W-1:0]  a;
  logic [MUL_W-1:0]  b;
  logic              is_signed;
  logic              out_valid;
  logic              out_ready;
  logic [PROD_W-1:0] result;

  modport master (
    output in_valid,
    output a,
    output b,
    output is_signed,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  result
  );

  modport slave (
    input  in_valid,
    input  a,
    input  b,
    input  is_signed,
    input  out_ready,
    output in_ready,
    output out_valid,
    output result
  );

endinterface

// File: rtl/seq_mult.sv
// Sequential shift-add multiplier, one multiplier bit per cycle.
// Signed operands are multiplied as magnitudes, sign fixed at the end.
module seq_mult
  import seq_mult_pkg::*;
#(
  parameter int WIDTH = MUL_W
) (
  input  logic        clk,
  input  logic        rst_n,
  seq_mult_if.slave   bus
);

  state_e               r_state;
  state_e               w_state_nxt;
  logic [2*WIDTH-1:0]   r_mcand;
  logic [2*WIDTH-1:0]   r_acc;
  logic [2*WIDTH-1:0]   r_result;
  logic [WIDTH-1:0]     r_mplier;
  logic                 r_neg;
  logic [CNT_W-1:0]     r_cnt;

  logic                 w_accept;
  logic                 w_last;
  logic [2*WIDTH-1:0]   w_acc_nxt;
  logic [2*WIDTH-1:0]   w_prod;

  assign w_accept  = (r_state == IDLE) && bus.in_valid;
  assign w_last    = (r_cnt == CNT_W'(WIDTH - 1));
  assign w_acc_nxt = r_mplier[0] ? (r_acc + r_mcand) : r_acc;
  assign w_prod    = r_neg ? -w_acc_nxt : w_acc_nxt;

  assign bus.in_ready  = (r_state == IDLE);
  assign bus.out_valid = (r_state == DONE);
  assign bus.result    = r_result;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state: accept, iterate WIDTH times, hold until taken.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE: if (bus.in_valid)  w_state_nxt = BUSY;
      BUSY: if (w_last)        w_state_nxt = DONE;
      DONE: if (bus.out_ready) w_state_nxt = IDLE;
      default:                 w_state_nxt = IDLE;
    endcase
  end

  // Datapath: latch magnitudes on accept, shift-add while busy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mcand  <= '0;
      r_mplier <= '0;
      r_neg    <= 1'b0;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_result <= '0;
    end else if (w_accept) begin
      r_mcand  <= {{WIDTH{1'b0}}, mag(bus.a, bus.is_signed)};
      r_mplier <= mag(bus.b, bus.is_signed);
      r_neg    <= bus.is_signed &
                  (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
      r_acc    <= '0;
      r_cnt    <= '0;
    end else if (r_state == BUSY) begin
      r_acc    <= w_acc_nxt;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_cnt    <= r_cnt + 1'b1;
      if (w_last) begin
        r_result <= w_prod;
      end
    end
  end

endmodule

// File: tb/tb_seq_mult.sv
// seq_mult bench: directed cases plus random traffic,
// checked each cycle against a cycle-count product model.
`timescale 1ns/1ps
module tb_seq_mult;
  import seq_mult_pkg::*;

  localparam int T = 10;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #(T/2) clk = ~clk;

  seq_mult_if bus ();

  seq_mult #(.WIDTH(MUL_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_vec = 0;
  int n_bad = 0;
  bit chk_en = 0;
  int cyc = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t",
               nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] ref_prod(
    input logic [15:0] a, input logic [15:0] b, input bit s);
    longint x, y;
    if (s) begin
      x = longint'($signed(a));
      y = longint'($signed(b));
    end else begin
      x = longint'(a);
      y = longint'(b);
    end
    return 32'(x * y);
  endfunction

  // Reference: an accepted pair is busy MUL_W cycles, then its
  // product is shown until out_ready; reset drops everything.
  int          m_left = 0;
  bit          m_done = 0;
  logic [31:0] m_pend = '0;
  logic [31:0] m_result = '0;
  bit          m_in_ready = 1;
  bit          m_out_valid = 0;

  always @(posedge clk) cyc++;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_left = 0;
      m_done = 0;
      m_result = '0;
    end else if (m_done) begin
      if (bus.out_ready) m_done = 0;
    end else if (m_left > 0) begin
      m_left--;
      if (m_left == 0) begin
        m_done = 1;
        m_result = m_pend;
      end
    end else if (bus.in_valid) begin
      m_left = MUL_W;
      m_pend = ref_prod(bus.a, bus.b, bus.is_signed);
    end
    m_in_ready = !m_done && (m_left == 0);
    m_out_valid = m_done;
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("in_ready", 32'(bus.in_ready), 32'(m_in_ready));
      chk("out_valid", 32'(bus.out_valid), 32'(m_out_valid));
      chk("result", bus.result, m_result);
    end
  end

  int t_acc;

  // Issue one pair from IDLE and wait for its product.
  task automatic do_op(input logic [15:0] a,
                       input logic [15:0] b,
                       input bit s,
                       input logic [31:0] exp,
                       input bit chk_lat);
    int n;
    int lat;
    n = 0;
    while (!bus.in_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!bus.in_ready) chk("idle_timeout", 0, 1);
    bus.a = a;
    bus.b = b;
    bus.is_signed = s;
    bus.in_valid = 1'b1;
    t_acc = cyc;
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.a = 16'($urandom);
    bus.b = 16'($urandom);
    bus.is_signed = 1'($urandom);
    lat = 0;
    while (!bus.out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    if (chk_lat) chk("latency", 32'(lat), 32'd16);
    chk("product", bus.result, exp);
  endtask

  function automatic logic [15:0] pick();
    case ($urandom_range(0, 5))
      0: return 16'h8000;
      1: return 16'hFFFF;
      2: return 16'h0000;
      3: return 16'h0001;
      default: return 16'($urandom);
    endcase
  endfunction

  int t0, t1, t2;
  logic [31:0] held;

  initial begin
    bus.in_valid = 1'b0;
    bus.a = '0;
    bus.b = '0;
    bus.is_signed = 1'b0;
    bus.out_ready = 1'b1;

    chk("model_u", ref_prod(16'hFFFF, 16'hFFFF, 0), 32'hFFFE0001);
    chk("model_s1", ref_prod(16'hFFFD, 16'd7, 1), 32'hFFFFFFEB);
    chk("model_s2", ref_prod(16'h8000, 16'h8000, 1), 32'h40000000);
    chk("model_s3", ref_prod(16'h8000, 16'h0001, 1), 32'hFFFF8000);

    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_result", bus.result, 32'd0);
    chk_en = 1;

    do_op(16'hFFFF, 16'hFFFF, 0, 32'hFFFE0001, 1);
    do_op(16'hFFFD, 16'd7, 1, 32'hFFFFFFEB, 1);
    do_op(16'h8000, 16'h8000, 1, 32'h40000000, 0);
    do_op(16'h8000, 16'h0001, 1, 32'hFFFF8000, 0);

    // Backpressure with an ignored in_valid pulse.
    @(negedge clk);
    bus.out_ready = 1'b0;
    do_op(16'd5, 16'd6, 0, 32'h0000001E, 1);
    for (int i = 0; i < 10; i++) begin
      bus.in_valid = (i == 4);
      bus.a = 16'h00FF;
      bus.b = 16'h00FF;
      @(negedge clk);
      chk("bp_result", bus.result, 32'h0000001E);
      chk("bp_in_ready", 32'(bus.in_ready), 32'd0);
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk("bp_release", 32'(bus.in_ready), 32'd1);

    // Reset at iteration 8 of a busy operation.
    bus.a = 16'h1234;
    bus.b = 16'h5678;
    bus.is_signed = 1'b0;
    bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (8) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_in_ready", 32'(bus.in_ready), 32'd1);
    chk("mid_out_valid", 32'(bus.out_valid), 32'd0);
    chk("mid_result", bus.result, 32'd0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    do_op(16'h0003, 16'hFFFB, 1, 32'hFFFFFFF1, 1);

    // Back-to-back with out_ready held high.
    do_op(16'h1234, 16'h0010, 0, 32'h00012340, 1);
    t0 = t_acc;
    do_op(16'h0000, 16'hABCD, 0, 32'h00000000, 1);
    t1 = t_acc;
    do_op(16'h0001, 16'h0001, 0, 32'h00000001, 1);
    t2 = t_acc;
    chk("spacing1", 32'(t1 - t0), 32'd18);
    chk("spacing2", 32'(t2 - t1), 32'd18);

    // Random traffic, including ignored pulses and stalls.
    for (int i = 0; i < 2500; i++) begin
      @(negedge clk);
      bus.in_valid = 1'($urandom);
      bus.a = pick();
      bus.b = pick();
      bus.is_signed = 1'($urandom);
      bus.out_ready = ($urandom_range(0, 3) != 0);
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end

endmodule
